// File: rtl/rr_arbiter_8_pkg.sv
// ============================================================================
// Module   : rr_arbiter_8_pkg
// Brief    : Shared types and constants for the 8-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_8_pkg;

  localparam int c_NUM_REQ = 8;
  localparam int c_IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Requester index after idx, wrapping 7 -> 0 through the 3-bit width.
  function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_8_if.sv
// ============================================================================
// Module   : rr_arbiter_8_if
// Brief    : Request/grant bundle between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;

  logic [c_NUM_REQ-1:0] req;
  logic                 done;
  logic [c_NUM_REQ-1:0] gnt;
  logic [c_IDX_W-1:0]   gnt_id;
  logic                 gnt_valid;
  logic                 timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter_8_decoder.sv
// ============================================================================
// Module   : decoder_3_to_8
// Brief    : Enabled 3-to-8 one-hot decoder; all-zero when disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_3_to_8 (
  input  logic       enable,
  input  logic [2:0] in,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    if (enable) out[in] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
// ============================================================================
// Module   : rr_arbiter_8
// Brief    : 8-requester round-robin arbiter with IDLE/GRANT FSM. Defining
//            ARB_TIMEOUT_EN bounds each grant to HOLD_MAX cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W-1:0] w_ptr_nxt;
  logic [c_IDX_W-1:0] r_gnt_id;
  logic [c_IDX_W-1:0] w_gnt_id_nxt;
  logic [c_IDX_W-1:0] w_pick;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_found;
  logic               w_release;
  logic               w_hold_hit;
  logic               w_timeout_nxt;
  logic               w_gnt_valid;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      w_idx = r_ptr + c_IDX_W'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_release = bus.done || !bus.req[r_gnt_id];

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_gnt_id_nxt = w_pick;
        end
      end
      GRANT: begin
        // A genuine release takes priority so a coincident limit never pulses timeout.
        if (w_release || w_hold_hit) begin
          w_state_nxt   = IDLE;
          w_ptr_nxt     = next_idx(r_gnt_id);
          w_timeout_nxt = !w_release;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt_id <= w_gnt_id_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_tenure;
  logic       r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tenure  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nxt;
      if (r_state == GRANT && w_state_nxt == GRANT) r_tenure <= r_tenure + 8'd1;
      else                                          r_tenure <= 8'd0;
    end
  end

  // Tenure counts completed GRANT cycles, so the limit edge is the HOLD_MAX-th one.
  assign w_hold_hit  = (r_state == GRANT) && (r_tenure == 8'(HOLD_MAX - 1));
  assign bus.timeout = r_timeout;
`else
  logic [8:0] w_unused_cfg;

  assign w_unused_cfg = {w_timeout_nxt, 8'(HOLD_MAX)};
  assign w_hold_hit   = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  assign w_gnt_valid   = (r_state == GRANT);
  assign bus.gnt_valid = w_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;

  decoder_3_to_8 u_decoder (
    .enable (w_gnt_valid),
    .in     (r_gnt_id),
    .out    (bus.gnt)
  );

endmodule

`default_nettype wire

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum grant tenure in cycles (range 1..255), used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  per-requester request, level-sensitive, bit i = requester i.
REQ-005 Port: done  input  1  current owner releases grant; sampled only in GRANT.
REQ-006 Port: gnt  output  8  one-hot grant; all-zero when no grant.
REQ-007 Port: gnt_id  output  3  binary index of the owner; valid only when gnt_valid=1.
REQ-008 Port: gnt_valid  output  1  high while any grant is held.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is revoked by timeout (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE: if req != 0 at a rising edge, the arbiter SHALL select the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8), load gnt_id, and enter GRANT; gnt is visible after that edge (one-cycle latency).
REQ-012 IDLE with req == 0 SHALL remain in IDLE with gnt=0, gnt_valid=0.
REQ-013 gnt SHALL always equal the 3-to-8 decode of gnt_id while gnt_valid=1, and 8'h00 otherwise.
REQ-014 GRANT SHALL be held unchanged while done=0 and req[gnt_id]=1, regardless of other requests.
REQ-015 Release: done=1 OR req[gnt_id]=0 at an edge in GRANT SHALL return to IDLE, clear gnt, and set ptr = gnt_id+1 (mod 8, 7 wraps to 0).
REQ-016 After every release there SHALL be exactly one IDLE cycle with gnt=0 before the next grant (no back-to-back grants).
REQ-017 done asserted in IDLE SHALL be ignored.
REQ-018 Requests arriving during GRANT SHALL not affect the current grant; they are arbitrated at the next IDLE edge.
REQ-019 A single persistent requester SHALL be re-granted after each one-cycle IDLE gap.
REQ-020 ptr SHALL change only on release/timeout, never on grant.

Reset
REQ-021 On rst_n=0 (asynchronous): state=IDLE, ptr=0, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, tenure counter=0.
REQ-022 Reset asserted during GRANT SHALL drop gnt immediately, without waiting for a clock edge.
REQ-023 The first edge after rst_n deasserts SHALL arbitrate normally from ptr=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit tenure counter SHALL clear on entering GRANT and increment each GRANT cycle; when it reaches HOLD_MAX without release, the next edge SHALL force release exactly as in REQ-015 and pulse timeout for one cycle (in the following IDLE cycle).
REQ-025 Simultaneous done=1 and timeout condition SHALL count as normal release; timeout SHALL not pulse.
REQ-026 Macro undefined: no counter is instantiated, tenure is unbounded, timeout is constant 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, GRANT), the requester-count constant (8) and the index width constant (3).
REQ-028 The one-hot grant decode SHALL reuse the existing decoder_3_to_8 as its single sub-module (enable=gnt_valid, in=gnt_id, out=gnt); round-robin search is inline.

Verification
REQ-029 Reset, then req=8'b0000_0101 held, done pulsed one cycle after each grant -> grants alternate gnt=8'h01, 8'h04, 8'h01, each separated by one gnt=0 cycle.
REQ-030 Owner 7 granted, req=8'hFF, done=1 -> ptr wraps to 0; next grant gnt=8'h01.
REQ-031 Requester 3 granted; req[5] rises mid-grant; req[3] drops -> release, one IDLE cycle, then gnt=8'h20, gnt_id=5.
REQ-032 rst_n pulled low mid-GRANT between clock edges -> gnt=8'h00, gnt_valid=0 immediately; after release, req=8'h80 -> gnt=8'h80 one edge later.
REQ-033 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h02 held, done=0 -> grant revoked after 4 GRANT cycles, timeout pulses 1 cycle, regrant gnt=8'h02 after the IDLE cycle.
REQ-034 ARB_TIMEOUT_EN, done=1 on the same edge the counter reaches HOLD_MAX -> release with timeout=0.
